dac_playback_ctrl: RTL and testbench

Sequencing controller for the DAC sample stream in the system clock domain. Generates the paced read strobe for the Ethernet-fed DAC sample FIFO. Holds off playback until a programmable prefill level is buffered, then issues exactly one read every (i_rate_div+1) clocks. On starvation it mutes, counts the event and re-buffers. Exports playback statistics for the control/status registers.

---
 rtl/dac_playback_ctrl.sv | 136 +++++++++++++
 tb/tb_dac_playback_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_playback_ctrl.sv
// Paced read-strobe generator for the DAC sample FIFO, with prefill gating, starvation mute and stats.
// Latency: first read one clock after STREAM entry, then one read every i_rate_div+1 clocks.
// Backpressure: FIFO level is the only throttle; an empty FIFO at a decision point mutes and re-buffers.
module dac_playback_ctrl #(
    parameter int LEVEL_W = 16,
    parameter int RATE_W  = 16,
    parameter int CNT_W   = 32
) (
    input  logic               i_sys_clk,
    input  logic               i_sys_rst,
    input  logic               i_enable,
    input  logic [RATE_W-1:0]  i_rate_div,
    input  logic [LEVEL_W-1:0] i_prefill_level,
    input  logic [LEVEL_W-1:0] i_fifo_level,
    input  logic               i_clear_stats,
    output logic               o_dac_data_rd,
    output logic               o_dac_mute,
    output logic [1:0]         o_state,
    output logic               o_starve,
    output logic [15:0]        o_starve_cnt,
    output logic [CNT_W-1:0]   o_sample_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_STREAM  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [RATE_W-1:0]  r_rate_cnt;
    logic [RATE_W-1:0]  w_rate_cnt_nxt;
    logic               r_rd;
    logic               w_rd_nxt;
    logic               r_mute;
    logic               r_starve;
    logic               w_starve_nxt;
    logic [15:0]        r_starve_cnt;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic [LEVEL_W-1:0] w_prefill_thr;
    logic [LEVEL_W-1:0] w_rd_pending;
    logic               w_has_data;

    // A zero threshold would let an empty FIFO start streaming, so it is floored at one word.
    assign w_prefill_thr = (i_prefill_level == '0) ? LEVEL_W'(1) : i_prefill_level;

    // The level lags our own strobe by a cycle; a read in flight this cycle is subtracted
    // so back-to-back reads never ask for a word that is not there.
    assign w_rd_pending = {{(LEVEL_W-1){1'b0}}, r_rd};
    assign w_has_data   = (i_fifo_level > w_rd_pending);

    // Next-state, rate counter and strobe decisions; disable overrides everything.
    always_comb begin
        w_state_nxt    = r_state;
        w_rate_cnt_nxt = r_rate_cnt;
        w_rd_nxt       = 1'b0;
        w_starve_nxt   = 1'b0;
        if (!i_enable) begin
            w_state_nxt    = ST_IDLE;
            w_rate_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_PREFILL;
                end
                ST_PREFILL: begin
                    if (i_fifo_level >= w_prefill_thr) begin
                        w_state_nxt    = ST_STREAM;
                        w_rate_cnt_nxt = '0;
                    end
                end
                ST_STREAM: begin
                    if (r_rate_cnt == '0) begin
                        if (w_has_data) begin
                            w_rd_nxt       = 1'b1;
                            w_rate_cnt_nxt = i_rate_div;
                        end else begin
                            w_state_nxt    = ST_PREFILL;
                            w_starve_nxt   = 1'b1;
                        end
                    end else begin
                        w_rate_cnt_nxt = r_rate_cnt - RATE_W'(1);
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_rate_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Control registers; mute tracks the next state so it drops together with STREAM entry.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state    <= ST_IDLE;
            r_rate_cnt <= '0;
            r_rd       <= 1'b0;
            r_mute     <= 1'b1;
            r_starve   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rate_cnt <= w_rate_cnt_nxt;
            r_rd       <= w_rd_nxt;
            r_mute     <= (w_state_nxt != ST_STREAM);
            r_starve   <= w_starve_nxt;
        end
    end

    // Statistics: clear wins over a same-cycle increment; starvation count saturates.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_starve_cnt <= '0;
            r_sample_cnt <= '0;
        end else if (i_clear_stats) begin
            r_starve_cnt <= '0;
            r_sample_cnt <= '0;
        end else begin
            if (w_starve_nxt && (r_starve_cnt != 16'hFFFF)) begin
                r_starve_cnt <= r_starve_cnt + 16'd1;
            end
            if (r_rd) begin
                r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            end
        end
    end

    assign o_dac_data_rd = r_rd;
    assign o_dac_mute    = r_mute;
    assign o_state       = r_state;
    assign o_starve      = r_starve;
    assign o_starve_cnt  = r_starve_cnt;
    assign o_sample_cnt  = r_sample_cnt;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Directed bench for dac_playback_ctrl with a simple FIFO level model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Level source is selectable: FIFO model, direct value, or state-driven starvation forcing.
module tb_dac_playback_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] rate_div;
    logic [15:0] prefill;
    logic [15:0] fifo_level;
    logic        clear_stats;
    logic        dac_rd;
    logic        dac_mute;
    logic [1:0]  state;
    logic        starve;
    logic [15:0] starve_cnt;
    logic [31:0] sample_cnt;

    int          n_pass;
    int          n_total;
    int          lvl_mode;
    logic [15:0] tb_level;
    int          tb_pushed;
    int          tb_reads;
    int          bad;
    int          nrd;

    dac_playback_ctrl #(.LEVEL_W(16), .RATE_W(16), .CNT_W(32)) dut (
        .i_sys_clk       (clk),
        .i_sys_rst       (rst),
        .i_enable        (enable),
        .i_rate_div      (rate_div),
        .i_prefill_level (prefill),
        .i_fifo_level    (fifo_level),
        .i_clear_stats   (clear_stats),
        .o_dac_data_rd   (dac_rd),
        .o_dac_mute      (dac_mute),
        .o_state         (state),
        .o_starve        (starve),
        .o_starve_cnt    (starve_cnt),
        .o_sample_cnt    (sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench FIFO: words pushed minus reads seen at earlier edges.
    always @(posedge clk) begin
        if (dac_rd) tb_reads <= tb_reads + 1;
    end

    assign fifo_level = (lvl_mode == 2) ? ((state == 2'd1) ? 16'd1 : 16'd0) :
                        (lvl_mode == 1) ? tb_level : 16'(tb_pushed - tb_reads);

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        tb_reads = 0; tb_pushed = 0; tb_level = '0; lvl_mode = 0;
        rst = 1'b1; enable = 1'b0; rate_div = '0; prefill = '0; clear_stats = 1'b0;
        bad = 0; nrd = 0;

        // Reset values
        step(2);
        chk("rst_rd", dac_rd, 0);
        chk("rst_mute", dac_mute, 1);
        chk("rst_state", state, 0);
        chk("rst_starve", starve, 0);
        chk("rst_starve_cnt", starve_cnt, 0);
        chk("rst_sample_cnt", sample_cnt, 0);

        // Basic stream: prefill 4, period 4, 10 words
        rst = 1'b0;
        enable = 1'b1; prefill = 16'd4; rate_div = 16'd3;
        lvl_mode = 0; tb_pushed = tb_reads + 10;
        step(1);
        chk("b_prefill_state", state, 1);
        chk("b_prefill_mute", dac_mute, 1);
        step(1);
        chk("b_stream_state", state, 2);
        chk("b_stream_mute", dac_mute, 0);
        chk("b_stream_rd", dac_rd, 0);
        for (int off = 1; off <= 40; off++) begin
            step(1);
            if (dac_rd) nrd++;
            if (dac_rd !== ((off <= 37) && ((off - 1) % 4 == 0))) bad++;
        end
        chk("b_read_pattern", bad, 0);
        chk("b_read_count", nrd, 10);
        step(1);
        chk("b_starve_pulse", starve, 1);
        chk("b_starve_state", state, 1);
        chk("b_starve_mute", dac_mute, 1);
        chk("b_starve_rd", dac_rd, 0);
        chk("b_starve_cnt", starve_cnt, 1);
        chk("b_sample_cnt", sample_cnt, 10);
        step(1);
        chk("b_starve_one_cycle", starve, 0);
        chk("b_stay_prefill", state, 1);

        // Full rate: 3 words, rate_div 0
        rate_div = 16'd0; prefill = 16'd3; tb_pushed = tb_pushed + 3;
        step(1);
        chk("f_stream_state", state, 2);
        nrd = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (dac_rd) nrd++;
        end
        chk("f_three_reads", nrd, 3);
        step(1);
        chk("f_no_fourth_rd", dac_rd, 0);
        chk("f_starve_pulse", starve, 1);
        chk("f_starve_state", state, 1);
        chk("f_starve_cnt", starve_cnt, 2);
        chk("f_sample_cnt", sample_cnt, 13);

        // Prefill gating: threshold 0 acts as 1
        lvl_mode = 1; tb_level = 16'd0; prefill = 16'd0;
        step(3);
        chk("p0_hold", state, 1);
        tb_level = 16'd1;
        step(1);
        chk("p0_enter", state, 2);
        enable = 1'b0;
        step(1);
        chk("p0_disable_state", state, 0);
        chk("p0_disable_rd", dac_rd, 0);
        enable = 1'b1; prefill = 16'd8; tb_level = 16'd0; rate_div = 16'd5;
        step(1);
        bad = 0;
        for (int l = 0; l < 8; l++) begin
            tb_level = 16'(l);
            step(1);
            if (state !== 2'd1) bad++;
        end
        chk("p8_hold_below", bad, 0);
        tb_level = 16'd8;
        step(1);
        chk("p8_enter", state, 2);

        // Disable mid-stream, rate_div 5
        step(1);
        chk("d_first_rd", dac_rd, 1);
        step(2);
        chk("d_gap_rd", dac_rd, 0);
        enable = 1'b0;
        step(1);
        chk("d_idle_state", state, 0);
        chk("d_idle_mute", dac_mute, 1);
        chk("d_idle_rd", dac_rd, 0);
        nrd = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (dac_rd) nrd++;
        end
        chk("d_no_more_rd", nrd, 0);
        chk("d_starve_cnt_kept", starve_cnt, 2);
        chk("d_sample_cnt", sample_cnt, 14);

        // Clear stats coincident with a read
        lvl_mode = 0; tb_pushed = tb_reads + 5; rate_div = 16'd0; prefill = 16'd1; enable = 1'b1;
        step(2);
        chk("c_stream_state", state, 2);
        step(1);
        chk("c_rd_high", dac_rd, 1);
        clear_stats = 1'b1;
        step(1);
        clear_stats = 1'b0;
        chk("c_sample_cleared", sample_cnt, 0);
        chk("c_starve_cleared", starve_cnt, 0);
        chk("c_rd_still", dac_rd, 1);
        step(1);
        chk("c_sample_after", sample_cnt, 1);

        // Asynchronous reset between edges while streaming
        #3;
        rst = 1'b1;
        #1;
        chk("a_rd", dac_rd, 0);
        chk("a_mute", dac_mute, 1);
        chk("a_state", state, 0);
        chk("a_starve", starve, 0);
        chk("a_sample_cnt", sample_cnt, 0);
        chk("a_starve_cnt", starve_cnt, 0);
        enable = 1'b0;
        step(1);
        rst = 1'b0;

        // Starvation counter saturation
        lvl_mode = 2; prefill = 16'd1; rate_div = 16'd0; enable = 1'b1;
        step(1 + 2 * 65534);
        chk("s_cnt_fffe", starve_cnt, 16'hFFFE);
        step(2);
        chk("s_cnt_ffff", starve_cnt, 16'hFFFF);
        chk("s_pulse", starve, 1);
        step(10);
        chk("s_cnt_saturated", starve_cnt, 16'hFFFF);
        chk("s_no_reads", sample_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
